rptr_empty_level: RTL and testbench
===================================

RPTR_EMPTY_LEVEL -- requirements
Module: rptr_empty_level

Interface
REQ-001 Parameter ADDR_SIZE, default 5, meaning log2 of FIFO depth (depth = 2^ADDR_SIZE).
REQ-002 Parameter POP_W, default 2, meaning width of the pop-count request (max burst 2^POP_W-1 entries per cycle).
REQ-003 Parameter AE_LEVEL, default 4, meaning almost-empty threshold in entries.
REQ-004 rclk  input  1  read clock; single clock domain, all state on posedge rclk.
REQ-005 rrst  input  1  reset, synchronous, active-high.
REQ-006 rq2_wptr  input  ADDR_SIZE+1  write pointer, Gray code, already synchronised to rclk.
REQ-007 rpop  input  POP_W  number of entries requested to pop this cycle (0 = idle).
REQ-008 raddr  output  ADDR_SIZE  read address = low ADDR_SIZE bits of binary read pointer.
REQ-009 rptr  output  ADDR_SIZE+1  registered Gray read pointer, for export to the write domain.
REQ-010 rempty  output  1  registered empty flag.
REQ-011 raempty  output  1  registered almost-empty flag.
REQ-012 rlevel  output  ADDR_SIZE+1  registered fill level, 0..2^ADDR_SIZE.
REQ-013 runderflow  output  1  sticky underflow error flag.
REQ-014 runderflow_clr  input  1  clears runderflow.

Function
REQ-015 wbin = Gray-to-binary of rq2_wptr, combinational, same cycle.
REQ-016 avail = (wbin - rbin) mod 2^(ADDR_SIZE+1), computed from current rbin and current rq2_wptr, not from registered rempty.
REQ-017 Pop is atomic: accept = rpop if rpop <= avail, else 0; no partial pops.
REQ-018 rbin_next = rbin + accept, wrapping modulo 2^(ADDR_SIZE+1); rgray_next = (rbin_next>>1) ^ rbin_next.
REQ-019 rbin and rptr load rbin_next and rgray_next every cycle; raddr updates the cycle after the accepted pop (1-cycle latency).
REQ-020 level_next = (wbin - rbin_next) mod 2^(ADDR_SIZE+1); rlevel <= level_next.
REQ-021 rempty <= (rgray_next == rq2_wptr); raempty <= (level_next <= AE_LEVEL).
REQ-022 rpop > avail (including any nonzero rpop when avail = 0): no pointer movement, runderflow set next cycle.
REQ-023 runderflow stays 1 until runderflow_clr or rrst; a simultaneous set and clear leaves it 1 (set wins).
REQ-024 rq2_wptr advance and pop in the same cycle: both are reflected in level_next; a new write is never accepted by the same-cycle pop beyond avail.
REQ-025 Full FIFO (avail = 2^ADDR_SIZE) yields rlevel = 2^ADDR_SIZE with no overflow of the rlevel width.
REQ-026 Pointer wrap at 2^(ADDR_SIZE+1) is transparent: level, flags and raddr remain correct across the MSB toggle.

Reset
REQ-027 On rrst high at a rclk edge: rbin = 0, rptr = 0, raddr = 0, rempty = 1, raempty = 1, rlevel = 0, runderflow = 0.
REQ-028 rpop and rq2_wptr are ignored while rrst is high; flags reflect rq2_wptr from the first cycle after rrst falls.
REQ-029 Reset asserted mid-burst discards the pop in that cycle with no underflow.

Structure
REQ-030 Gray/binary conversion functions and the pointer-width localparam (ADDR_SIZE+1) SHALL live in the shared package fifo_pkg, reused by the write-side block.
REQ-031 One sub-module, gray2bin (parametrised width, combinational), SHALL be instantiated for rq2_wptr conversion.
REQ-032 All other logic is flat in rptr_empty_level; no additional clock or reset domains.

Verification (ADDR_SIZE=3, POP_W=2, AE_LEVEL=2)
REQ-033 Reset with rq2_wptr = Gray(5) -> during reset rempty=1, rlevel=0; one cycle after release rlevel=5, rempty=0, raempty=0.
REQ-034 Level 5, rpop=3 -> next cycle raddr=3, rptr=Gray(3)=4'b0010, rlevel=2, raempty=1, rempty=0.
REQ-035 Level 2, rpop=3 -> rbin unchanged, rlevel=2, runderflow=1 and held until runderflow_clr pulse, then 0.
REQ-036 rbin=14, wptr=Gray(1) (level 3), rpop=3 -> rbin=1 (wrap), raddr=1, rempty=1, rlevel=0, runderflow=0.
REQ-037 Level 8 (wbin=8, rbin=0) -> rlevel=8 (4'b1000), rempty=0; then rpop=1 with wptr advanced to Gray(9) in the same cycle -> rlevel=8.
REQ-038 Random rpop/wptr stream vs. reference model: rlevel, rempty, raempty, runderflow match every cycle; no accepted pop ever exceeds avail.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and pointer-width sizing,
// used by both the read-side and write-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 5;
  localparam int FIFO_PTR_W     = FIFO_ADDR_SIZE + 1;

  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  // Callers zero-extend into 32 bits and cast the result back to their width.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int W = FIFO_PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray_to_bin(32'(gray)));

endmodule

// File: rtl/rptr_empty_level.sv
// Read-side FIFO pointer: atomic multi-entry pops, registered Gray pointer,
// empty/almost-empty flags, fill level and a sticky underflow flag.
module rptr_empty_level
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int POP_W     = 2,
  parameter int AE_LEVEL  = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [POP_W-1:0]     rpop,
  input  logic                 runderflow_clr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 raempty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 runderflow
);

  localparam int PW = ptr_width(ADDR_SIZE);

  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin;
  logic [PW-1:0] avail;
  logic [PW-1:0] pop_ext;
  logic [PW-1:0] accept;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] level_next;
  logic          pop_too_big;

  gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  // Availability comes from the live write pointer, so a pop is never gated by
  // a stale registered empty flag; a pop larger than avail is rejected whole.
  always_comb begin
    avail       = wbin - rbin;
    pop_ext     = PW'(rpop);
    pop_too_big = (pop_ext > avail);
    accept      = pop_too_big ? '0 : pop_ext;
    rbin_next   = rbin + accept;
    rgray_next  = PW'(bin_to_gray(32'(rbin_next)));
    level_next  = wbin - rbin_next;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbin_next;
      rptr       <= rgray_next;
      rempty     <= (rgray_next == rq2_wptr);
      raempty    <= (32'(level_next) <= AE_LEVEL);
      rlevel     <= level_next;
      // A fresh underflow in the same cycle as a clear keeps the flag set.
      runderflow <= pop_too_big | (runderflow & ~runderflow_clr);
    end
  end

  assign raddr = rbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed self-checking bench for rptr_empty_level (ADDR_SIZE=3, POP_W=2, AE_LEVEL=2).
module tb_rptr_empty_level;

  logic       clock;
  logic       rrst;
  logic [3:0] rq2_wptr;
  logic [1:0] rpop;
  logic       runderflow_clr;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       runderflow;

  int checks = 0;
  int errors = 0;

  rptr_empty_level #(.ADDR_SIZE(3), .POP_W(2), .AE_LEVEL(2)) dut (
    .rclk           (clock),
    .rrst           (rrst),
    .rq2_wptr       (rq2_wptr),
    .rpop           (rpop),
    .runderflow_clr (runderflow_clr),
    .raddr          (raddr),
    .rptr           (rptr),
    .rempty         (rempty),
    .raempty        (raempty),
    .rlevel         (rlevel),
    .runderflow     (runderflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] wgray,
                               input logic [1:0] pop, input logic clr);
    rrst           = rst;
    rq2_wptr       = wgray;
    rpop           = pop;
    runderflow_clr = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step, input logic [2:0] e_addr,
                             input logic [3:0] e_ptr, input logic e_empty,
                             input logic e_aempty, input logic [3:0] e_level,
                             input logic e_uf);
    checkOne({step, ".raddr"},      {1'b0, raddr},      {1'b0, e_addr});
    checkOne({step, ".rptr"},       rptr,               e_ptr);
    checkOne({step, ".rempty"},     {3'b0, rempty},     {3'b0, e_empty});
    checkOne({step, ".raempty"},    {3'b0, raempty},    {3'b0, e_aempty});
    checkOne({step, ".rlevel"},     rlevel,             e_level);
    checkOne({step, ".runderflow"}, {3'b0, runderflow}, {3'b0, e_uf});
  endtask

  // Gray codes used below: 1=0001 3=0010 4=0110 5=0111 7=0100 10=1111
  // 11=1110 12=1010 13=1011 14=1001
  initial begin
    rrst = 1'b1; rq2_wptr = '0; rpop = '0; runderflow_clr = 1'b0;

    // Reset ignores the pop request and the non-empty write pointer
    applyStimulus(1'b1, 4'b0111, 2'd3, 1'b0);
    checkOutput("reset",      3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0111, 2'd0, 1'b0);
    checkOutput("release",    3'd0, 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0);

    applyStimulus(1'b0, 4'b0111, 2'd3, 1'b0);
    checkOutput("pop3",       3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b0);

    // Underflow is atomic, sticky, and wins over a simultaneous clear
    applyStimulus(1'b0, 4'b0111, 2'd3, 1'b0);
    checkOutput("underflow",  3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b0, 4'b0111, 2'd0, 1'b0);
    checkOutput("uf_hold",    3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b0, 4'b0111, 2'd0, 1'b1);
    checkOutput("uf_clr",     3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b0, 4'b0111, 2'd3, 1'b1);
    checkOutput("uf_setwins", 3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b0, 4'b0111, 2'd0, 1'b1);
    checkOutput("uf_clr2",    3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b0);

    // Full FIFO, then pop while the write pointer advances
    applyStimulus(1'b0, 4'b1110, 2'd0, 1'b0);
    checkOutput("full",       3'd3, 4'b0010, 1'b0, 1'b0, 4'd8, 1'b0);
    applyStimulus(1'b0, 4'b1010, 2'd1, 1'b0);
    checkOutput("full_popw",  3'd4, 4'b0110, 1'b0, 1'b0, 4'd8, 1'b0);

    // Drain towards rbin=14
    applyStimulus(1'b0, 4'b1001, 2'd3, 1'b0);
    checkOutput("drain1",     3'd7, 4'b0100, 1'b0, 1'b0, 4'd7, 1'b0);
    applyStimulus(1'b0, 4'b1001, 2'd3, 1'b0);
    checkOutput("drain2",     3'd2, 4'b1111, 1'b0, 1'b0, 4'd4, 1'b0);
    applyStimulus(1'b0, 4'b1001, 2'd3, 1'b0);
    checkOutput("drain3",     3'd5, 4'b1011, 1'b0, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 4'b1001, 2'd1, 1'b0);
    checkOutput("drain4",     3'd6, 4'b1001, 1'b1, 1'b1, 4'd0, 1'b0);

    // Any pop while empty underflows without moving the pointer
    applyStimulus(1'b0, 4'b1001, 2'd1, 1'b0);
    checkOutput("empty_pop",  3'd6, 4'b1001, 1'b1, 1'b1, 4'd0, 1'b1);

    // Write pointer wraps past the MSB, then the read pointer wraps too
    applyStimulus(1'b0, 4'b0001, 2'd0, 1'b1);
    checkOutput("wwrap",      3'd6, 4'b1001, 1'b0, 1'b0, 4'd3, 1'b0);
    applyStimulus(1'b0, 4'b0001, 2'd3, 1'b0);
    checkOutput("rwrap",      3'd1, 4'b0001, 1'b1, 1'b1, 4'd0, 1'b0);

    // Reset mid-burst discards the pop and raises no underflow
    applyStimulus(1'b0, 4'b0110, 2'd0, 1'b0);
    checkOutput("pre_rst",    3'd1, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b0);
    applyStimulus(1'b1, 4'b0110, 2'd2, 1'b0);
    checkOutput("mid_rst",    3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0110, 2'd0, 1'b0);
    checkOutput("post_rst",   3'd0, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
